uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a small transmit FIFO in front of it. The data bit
//   count, parity mode and stop length are configurable at runtime. A break
//   request can force the line low.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   s_tick           oversample enable, one clk wide, OVS pulses per bit
//   tx_data/valid    write side of the FIFO; a write happens when tx_valid
//                    and tx_ready are both high on a rising edge
//   tx_ready         FIFO not full
//   dbit_select_i    000..100 selects 5..9 data bits, clamped to DBIT_MAX
//   sbit_select_i    00 = 1, 01 = 1.5, 1x = 2 stop bits
//   parity_select_i  001 even, 010 odd, 011 mark, 100 space, others none
//   break_i          hold the line low once the current frame has finished
//   tx               registered serial line, idle high
//   tx_busy          FSM is not idle
//   tx_done_tick     one-clk pulse after each completed data frame
//   fifo_count       number of words waiting in the FIFO
module uart_tx_fifo #(
    parameter int DBIT_MAX   = 9,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              s_tick,
    input  logic [DBIT_MAX-1:0]               tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    input  logic [2:0]                        dbit_select_i,
    input  logic [1:0]                        sbit_select_i,
    input  logic [2:0]                        parity_select_i,
    input  logic                              break_i,
    output logic                              tx,
    output logic                              tx_busy,
    output logic                              tx_done_tick,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(2 * OVS);
    localparam logic [TW-1:0] OVS_LAST = TW'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DBIT_MAX-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                push, pop;
    logic [DBIT_MAX-1:0] fifo_head;

    assign tx_ready   = (count != CW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign fifo_head  = mem[rd_ptr];
    assign fifo_count = count;

    // Pointers wrap naturally because the depth is a power of two. A push
    // and a pop on the same edge cancel out in the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= tx_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decode of the live configuration. It only matters on the edge where
    // a word is popped; after that the frame runs on latched copies.
    // ------------------------------------------------------------------
    logic [3:0]          sel_bits;
    logic [DBIT_MAX-1:0] sel_mask;
    logic                sel_par_en, sel_par_val;
    logic [TW-1:0]       sel_stop_last;

    always_comb begin
        sel_bits = 4'(dbit_select_i) + 4'd5;
        if (sel_bits > 4'(DBIT_MAX)) begin
            sel_bits = 4'(DBIT_MAX);
        end
        sel_mask = '0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            sel_mask[i] = (i < int'(sel_bits));
        end
        case (parity_select_i)
            3'b001:  begin sel_par_en = 1'b1; sel_par_val =  ^(fifo_head & sel_mask); end
            3'b010:  begin sel_par_en = 1'b1; sel_par_val = ~^(fifo_head & sel_mask); end
            3'b011:  begin sel_par_en = 1'b1; sel_par_val = 1'b1; end
            3'b100:  begin sel_par_en = 1'b1; sel_par_val = 1'b0; end
            default: begin sel_par_en = 1'b0; sel_par_val = 1'b0; end
        endcase
        case (sbit_select_i)
            2'b00:   sel_stop_last = TW'(OVS - 1);
            2'b01:   sel_stop_last = TW'(3 * OVS / 2 - 1);
            default: sel_stop_last = TW'(2 * OVS - 1);
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t              state, state_next;
    logic [TW-1:0]       tick_cnt, tick_next;
    logic [3:0]          bit_cnt, bit_next;
    logic [DBIT_MAX-1:0] shreg, shreg_next;
    logic [3:0]          nbits, nbits_next;
    logic [TW-1:0]       stop_last, stop_last_next;
    logic                par_en, par_en_next;
    logic                par_val, par_val_next;
    logic                brk_stop, brk_stop_next;
    logic                tx_next, done_next;
    logic                tick_end, start_frame;

    // State register. The tx line is registered on the same edge as the
    // state, so its value is derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            nbits        <= 4'd8;
            stop_last    <= OVS_LAST;
            par_en       <= 1'b0;
            par_val      <= 1'b0;
            brk_stop     <= 1'b0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_next;
            tick_cnt     <= tick_next;
            bit_cnt      <= bit_next;
            shreg        <= shreg_next;
            nbits        <= nbits_next;
            stop_last    <= stop_last_next;
            par_en       <= par_en_next;
            par_val      <= par_val_next;
            brk_stop     <= brk_stop_next;
            tx           <= tx_next;
            tx_done_tick <= done_next;
        end
    end

    // Next-state logic. A frame start (pop) can come from IDLE or straight
    // from the end of STOP, so it is handled once after the case statement.
    // brk_stop marks the mark period that follows a break, which finishes
    // without a done pulse.
    always_comb begin
        state_next     = state;
        tick_next      = tick_cnt;
        bit_next       = bit_cnt;
        shreg_next     = shreg;
        nbits_next     = nbits;
        stop_last_next = stop_last;
        par_en_next    = par_en;
        par_val_next   = par_val;
        brk_stop_next  = brk_stop;
        done_next      = 1'b0;
        pop            = 1'b0;
        start_frame    = 1'b0;
        tick_end       = s_tick && (tick_cnt == OVS_LAST);

        case (state)
            IDLE: begin
                if (break_i) begin
                    state_next = BREAK;
                end else if (count != '0) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (tick_end) begin
                    state_next = DATA;
                    tick_next  = '0;
                end else if (s_tick) begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            DATA: begin
                if (tick_end) begin
                    tick_next  = '0;
                    shreg_next = shreg >> 1;
                    if (bit_cnt == nbits - 4'd1) begin
                        state_next = par_en ? PARITY : STOP;
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end else if (s_tick) begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (tick_end) begin
                    state_next = STOP;
                    tick_next  = '0;
                end else if (s_tick) begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            STOP: begin
                if (s_tick && (tick_cnt == stop_last)) begin
                    tick_next     = '0;
                    done_next     = !brk_stop;
                    brk_stop_next = 1'b0;
                    if (!break_i && (count != '0)) begin
                        start_frame = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (s_tick) begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            BREAK: begin
                if (!break_i) begin
                    state_next     = STOP;
                    tick_next      = '0;
                    stop_last_next = OVS_LAST;
                    brk_stop_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (start_frame) begin
            pop            = 1'b1;
            state_next     = START;
            tick_next      = '0;
            bit_next       = '0;
            shreg_next     = fifo_head;
            nbits_next     = sel_bits;
            stop_last_next = sel_stop_last;
            par_en_next    = sel_par_en;
            par_val_next   = sel_par_val;
        end

        case (state_next)
            START, BREAK: tx_next = 1'b0;
            DATA:         tx_next = shreg_next[0];
            PARITY:       tx_next = par_val_next;
            default:      tx_next = 1'b1;
        endcase
    end

    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. Every write pushes the frame it should
//   produce into a queue. A monitor on the falling clock edge decodes each
//   frame from the tx line and compares it with the queue head.
module tb_uart_tx_fifo;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic [8:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] dbit_select_i;
    logic [1:0] sbit_select_i;
    logic [2:0] parity_select_i;
    logic       break_i;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;
    logic [2:0] fifo_count;

    uart_tx_fifo #(.DBIT_MAX(9), .OVS(OVS), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_tick          (s_tick),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .dbit_select_i   (dbit_select_i),
        .sbit_select_i   (sbit_select_i),
        .parity_select_i (parity_select_i),
        .break_i         (break_i),
        .tx              (tx),
        .tx_busy         (tx_busy),
        .tx_done_tick    (tx_done_tick),
        .fifo_count      (fifo_count)
    );

    typedef struct {
        bit         is_break;
        logic [8:0] data;
        int         nbits;
        bit         par_en;
        bit         par_val;
        int         stop_ticks;
    } exp_t;

    typedef enum {M_IDLE, M_BITS, M_STOP, M_BRK, M_BSTOP} mstate_t;

    exp_t    exp_q[$];
    exp_t    cur;
    mstate_t mstate = M_IDLE;
    int      total = 0;
    int      bad = 0;
    int      done_count = 0;
    int      frame_no = 0;
    int      idx, stop_cnt, nbit_total, kbit;
    bit      stop_low, ebit;
    logic    tx_prev = 1'b1;

    // 10 ns clock
    always #5 clk = ~clk;

    // s_tick is high every other clock cycle
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 s_tick = ~s_tick;
        end
    end

    // Hang guard
    initial begin
        #600000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic setConfig(input logic [2:0] d, input logic [1:0] s, input logic [2:0] p);
        dbit_select_i   = d;
        sbit_select_i   = s;
        parity_select_i = p;
    endtask

    // Write one word and queue the frame it should produce.
    task automatic applyStimulus(input logic [8:0] word, input logic [8:0] exp_data,
                                 input int nb, input bit pen, input bit pval, input int st);
        exp_t e;
        e.is_break   = 1'b0;
        e.data       = exp_data;
        e.nbits      = nb;
        e.par_en     = pen;
        e.par_val    = pval;
        e.stop_ticks = st;
        exp_q.push_back(e);
        tx_data  = word;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic pushBreak();
        exp_t e;
        e.is_break   = 1'b1;
        e.data       = '0;
        e.nbits      = 0;
        e.par_en     = 1'b0;
        e.par_val    = 1'b0;
        e.stop_ticks = OVS;
        exp_q.push_back(e);
    endtask

    task automatic waitTicks(input int n);
        int k = 0;
        while (k < n) begin
            @(negedge clk);
            if (s_tick) k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitBusy();
        int  n = 0;
        bit  ok = 1'b0;
        while (n < 20 && !ok) begin
            @(posedge clk);
            #1 n++;
            ok = tx_busy;
        end
        checkOutput("busy_seen", int'(ok), 1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        bit ok = 1'b0;
        while (n < budget && !ok) begin
            @(posedge clk);
            #1 n++;
            if (exp_q.size() == 0 && mstate == M_IDLE && !tx_busy) ok = 1'b1;
        end
        checkOutput("drain", int'(ok), 1);
    endtask

    // Monitor: decodes the serial line. The steps run in order so that a
    // frame which starts on the same edge as the previous done pulse is
    // picked up on that same sample.
    always @(negedge clk) begin
        if (reset) begin
            mstate  = M_IDLE;
            tx_prev = 1'b1;
        end else begin
            if (tx_done_tick) begin
                done_count++;
                checkOutput("done_in_stop", int'(mstate == M_STOP), 1);
                if (mstate == M_STOP) begin
                    checkOutput($sformatf("frame%0d_stop_ticks", frame_no), stop_cnt, cur.stop_ticks);
                    checkOutput($sformatf("frame%0d_stop_low", frame_no), int'(stop_low), 0);
                    mstate = M_IDLE;
                end
            end
            if (mstate == M_STOP && s_tick) begin
                stop_cnt++;
                if (!tx) stop_low = 1'b1;
            end
            if (mstate == M_IDLE && tx_prev && !tx) begin
                checkOutput("frame_queued", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    frame_no++;
                    checkOutput($sformatf("frame%0d_kind", frame_no), int'(break_i), int'(cur.is_break));
                    idx        = 0;
                    nbit_total = 1 + cur.nbits + int'(cur.par_en);
                    mstate     = cur.is_break ? M_BRK : M_BITS;
                end
            end
            if (mstate == M_BITS && s_tick) begin
                if (idx % OVS == OVS / 2) begin
                    kbit = idx / OVS;
                    if (kbit == 0)               ebit = 1'b0;
                    else if (kbit <= cur.nbits)  ebit = cur.data[kbit-1];
                    else                         ebit = cur.par_val;
                    checkOutput($sformatf("frame%0d_bit%0d", frame_no, kbit), int'(tx), int'(ebit));
                end
                idx++;
                if (idx == nbit_total * OVS) begin
                    mstate   = M_STOP;
                    stop_cnt = 0;
                    stop_low = 1'b0;
                end
            end
            if (mstate == M_BRK && tx) begin
                checkOutput("break_release", int'(break_i), 0);
                mstate   = M_BSTOP;
                stop_cnt = 0;
                stop_low = 1'b0;
            end
            if (mstate == M_BSTOP) begin
                if (!tx_busy) begin
                    checkOutput("break_mark_ticks", stop_cnt, cur.stop_ticks);
                    checkOutput("break_mark_low", int'(stop_low), 0);
                    mstate = M_IDLE;
                end else if (s_tick) begin
                    stop_cnt++;
                    if (!tx) stop_low = 1'b1;
                end
            end
            tx_prev = tx;
        end
    end

    int d0, n, idle_after_done;
    int exp_cnt [5] = '{1, 1, 2, 3, 4};
    logic [8:0] words [5] = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};

    initial begin
        reset    = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        break_i  = 1'b0;
        setConfig(3'b011, 2'b00, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", int'(tx), 1);
        checkOutput("reset_busy", int'(tx_busy), 0);
        checkOutput("reset_done", int'(tx_done_tick), 0);
        checkOutput("reset_count", int'(fifo_count), 0);
        checkOutput("reset_ready", int'(tx_ready), 1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 0x55, write latency, config change mid-frame ignored
        d0 = done_count;
        applyStimulus(9'h055, 9'h055, 8, 1'b0, 1'b0, 16);
        checkOutput("lat_tx_after_write", int'(tx), 1);
        checkOutput("lat_count_after_write", int'(fifo_count), 1);
        @(posedge clk);
        #1;
        checkOutput("lat_tx_start", int'(tx), 0);
        checkOutput("lat_count_after_pop", int'(fifo_count), 0);
        checkOutput("lat_busy", int'(tx_busy), 1);
        setConfig(3'b000, 2'b10, 3'b010);
        waitIdle(3000);
        checkOutput("t1_done_ticks", done_count - d0, 1);

        // 9 data bits with each parity mode
        setConfig(3'b100, 2'b00, 3'b010);
        applyStimulus(9'h1FF, 9'h1FF, 9, 1'b1, 1'b0, 16);
        waitIdle(3000);
        setConfig(3'b100, 2'b00, 3'b001);
        applyStimulus(9'h0FF, 9'h0FF, 9, 1'b1, 1'b0, 16);
        waitIdle(3000);
        setConfig(3'b100, 2'b00, 3'b011);
        applyStimulus(9'h0FF, 9'h0FF, 9, 1'b1, 1'b1, 16);
        waitIdle(3000);
        setConfig(3'b100, 2'b00, 3'b100);
        applyStimulus(9'h1FF, 9'h1FF, 9, 1'b1, 1'b0, 16);
        waitIdle(3000);

        // Stop lengths: 1.5, 2 and the 11 encoding
        setConfig(3'b011, 2'b01, 3'b000);
        applyStimulus(9'h0A3, 9'h0A3, 8, 1'b0, 1'b0, 24);
        waitIdle(3000);
        setConfig(3'b011, 2'b10, 3'b000);
        applyStimulus(9'h03C, 9'h03C, 8, 1'b0, 1'b0, 32);
        waitIdle(3000);
        setConfig(3'b011, 2'b11, 3'b000);
        applyStimulus(9'h0C5, 9'h0C5, 8, 1'b0, 1'b0, 32);
        waitIdle(3000);

        // 5 bits, even parity over the low 5 bits only (1,1,0,0,1 -> 1)
        setConfig(3'b000, 2'b00, 3'b001);
        applyStimulus(9'h1F3, 9'h013, 5, 1'b1, 1'b1, 16);
        waitIdle(3000);
        // select 111 clamps to 9 bits, parity 101 means none
        setConfig(3'b111, 2'b00, 3'b101);
        applyStimulus(9'h155, 9'h155, 9, 1'b0, 1'b0, 16);
        waitIdle(3000);

        // Five back-to-back writes, then one write while full
        setConfig(3'b011, 2'b00, 3'b000);
        d0 = done_count;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(words[i], words[i], 8, 1'b0, 1'b0, 16);
            checkOutput($sformatf("b2b_count%0d", i), int'(fifo_count), exp_cnt[i]);
        end
        checkOutput("b2b_ready_full", int'(tx_ready), 0);
        tx_data  = 9'h066;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        checkOutput("b2b_count_full_write", int'(fifo_count), 4);
        idle_after_done = 0;
        n = 0;
        while (done_count - d0 < 5 && n < 5000) begin
            @(posedge clk);
            #1 n++;
            if (tx_done_tick && !tx_busy) idle_after_done++;
        end
        checkOutput("b2b_done_ticks", done_count - d0, 5);
        checkOutput("b2b_idle_after_done", idle_after_done, 1);
        waitIdle(3000);

        // Break raised near the end of a frame, held for 40 ticks
        d0 = done_count;
        applyStimulus(9'h055, 9'h055, 8, 1'b0, 1'b0, 16);
        pushBreak();
        waitBusy();
        waitTicks(140);
        break_i = 1'b1;
        waitTicks(40);
        checkOutput("break_line_low", int'(tx), 0);
        break_i = 1'b0;
        waitIdle(3000);
        checkOutput("break_done_ticks", done_count - d0, 1);

        // Reset in the middle of data bit 3 with two words queued
        d0 = done_count;
        applyStimulus(9'h05A, 9'h05A, 8, 1'b0, 1'b0, 16);
        applyStimulus(9'h00F, 9'h00F, 8, 1'b0, 1'b0, 16);
        applyStimulus(9'h0F0, 9'h0F0, 8, 1'b0, 1'b0, 16);
        waitBusy();
        waitTicks(72);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_tx", int'(tx), 1);
        checkOutput("midreset_count", int'(fifo_count), 0);
        checkOutput("midreset_busy", int'(tx_busy), 0);
        checkOutput("midreset_ready", int'(tx_ready), 1);
        checkOutput("midreset_done", int'(tx_done_tick), 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(9'h0C3, 9'h0C3, 8, 1'b0, 1'b0, 16);
        waitIdle(3000);
        checkOutput("midreset_done_ticks", done_count - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
